// File: rtl/control_secuenciador_pkg.sv
// Shared types and constants for the control_secuenciador sequencer.
package control_secuenciador_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_T     = 3'd1,
        OPERATE    = 3'd2,
        RELOAD_T   = 3'd3,
        OPERATE2   = 3'd4,
        WRITE_BACK = 3'd5,
        DONE       = 3'd6
    } state_t;

    // Operation codes
    localparam logic [1:0] OP_ADD   = 2'b00;  // C = A + B
    localparam logic [1:0] OP_SUB   = 2'b01;  // C = A - B
    localparam logic [1:0] OP_ADD_A = 2'b10;  // A = A + B
    localparam logic [1:0] OP_ADD3  = 2'b11;  // C = A + B + C

    // ALU select encodings, packed as {S,R}
    localparam logic [1:0] ALU_OFF = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;

endpackage

// File: rtl/control_secuenciador_detector_flanco.sv
// Registered rising-edge detector for the start request.
module detector_flanco (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;
    logic armed;

    // Register the input; only arm once the input has been seen low after reset,
    // so a level held high through reset release never counts as an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_q   <= 1'b0;
            armed <= 1'b0;
        end else begin
            d_q <= d;
            if (!d) begin
                armed <= 1'b1;
            end
        end
    end

    assign rise = d & ~d_q & armed;

endmodule

// File: rtl/control_secuenciador.sv
// Moore sequencer driving the bus enables, write enables and ALU select of the datapath.
module control_secuenciador
    import control_secuenciador_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       xs,
    input  logic [1:0] op,
    output logic       Ra,
    output logic       Rb,
    output logic       Rc,
    output logic       Rac,
    output logic       Wa,
    output logic       Wb,
    output logic       Wc,
    output logic       Wac,
    output logic       Wt,
    output logic       S,
    output logic       R,
    output logic       busy,
    output logic       fin
);

    // N only records the datapath width this controller is paired with.
    if (N == 0) begin : g_zero_width
    end

    state_t     state;
    state_t     state_next;
    logic [1:0] op_q;
    logic [1:0] alu_sel;
    logic       start;

    detector_flanco u_detector_flanco (
        .clk   (clk),
        .reset (reset),
        .d     (xs),
        .rise  (start)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the operation code when a start is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q <= OP_ADD;
        end else if (state == IDLE && start) begin
            op_q <= op;
        end
    end

    // Next-state and output decode from registered state only.
    always_comb begin
        state_next = IDLE;
        Ra      = 1'b0;
        Rb      = 1'b0;
        Rc      = 1'b0;
        Rac     = 1'b0;
        Wa      = 1'b0;
        Wb      = 1'b0;
        Wc      = 1'b0;
        Wac     = 1'b0;
        Wt      = 1'b0;
        alu_sel = ALU_OFF;
        busy    = 1'b0;
        fin     = 1'b0;
        case (state)
            IDLE: begin
                state_next = start ? LOAD_T : IDLE;
            end
            LOAD_T: begin
                busy       = 1'b1;
                Ra         = 1'b1;
                Wt         = 1'b1;
                state_next = OPERATE;
            end
            OPERATE: begin
                busy       = 1'b1;
                Rb         = 1'b1;
                Wac        = 1'b1;
                alu_sel    = (op_q == OP_SUB) ? ALU_SUB : ALU_ADD;
                state_next = (op_q == OP_ADD3) ? RELOAD_T : WRITE_BACK;
            end
            RELOAD_T: begin
                busy       = 1'b1;
                Rac        = 1'b1;
                Wt         = 1'b1;
                state_next = OPERATE2;
            end
            OPERATE2: begin
                busy       = 1'b1;
                Rc         = 1'b1;
                Wac        = 1'b1;
                alu_sel    = ALU_ADD;
                state_next = WRITE_BACK;
            end
            WRITE_BACK: begin
                busy       = 1'b1;
                Rac        = 1'b1;
                Wa         = (op_q == OP_ADD_A);
                Wc         = (op_q != OP_ADD_A);
                state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                fin        = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        S = alu_sel[1];
        R = alu_sel[0];
    end

endmodule

// File: tb/tb_control_secuenciador.sv
// Self-checking bench: control_secuenciador plus a behavioural datapath (A, B, C, T, AC).
module tb_control_secuenciador;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       xs = 1'b0;
    logic [1:0] op = 2'b00;
    logic       Ra, Rb, Rc, Rac, Wa, Wb, Wc, Wac, Wt, S, R, busy, fin;

    control_secuenciador #(.N(N)) dut (
        .clk(clk), .reset(reset), .xs(xs), .op(op),
        .Ra(Ra), .Rb(Rb), .Rc(Rc), .Rac(Rac),
        .Wa(Wa), .Wb(Wb), .Wc(Wc), .Wac(Wac), .Wt(Wt),
        .S(S), .R(R), .busy(busy), .fin(fin)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: one shared bus, T/AC through the ALU.
    logic [N-1:0] ra, rb, rc, rt, rac, bus, alu;
    logic [N-1:0] pa, pb, pc;
    logic         preset = 1'b0;

    always_comb begin
        bus = '0;
        if (Ra)       bus = ra;
        else if (Rb)  bus = rb;
        else if (Rc)  bus = rc;
        else if (Rac) bus = rac;
    end

    always_comb begin
        alu = '0;
        if (S && !R)      alu = rt + bus;
        else if (!S && R) alu = rt - bus;
    end

    always @(posedge clk) begin
        if (preset) begin
            ra <= pa; rb <= pb; rc <= pc;
        end else begin
            if (Wt)  rt  <= bus;
            if (Wac) rac <= alu;
            if (Wa)  ra  <= bus;
            if (Wb)  rb  <= bus;
            if (Wc)  rc  <= bus;
        end
    end

    logic [12:0] outs;
    assign outs = {Ra, Rb, Rc, Rac, Wa, Wb, Wc, Wac, Wt, S, R, busy, fin};

    int total = 0;
    int bad = 0;
    int excl_bad = 0;

    // Bus exclusivity watched every cycle.
    always @(negedge clk) begin
        if (!$onehot0({Ra, Rb, Rc, Rac})) excl_bad <= excl_bad + 1;
    end

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic preset_regs(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c);
        @(negedge clk);
        pa = a; pb = b; pc = c; preset = 1'b1;
        @(negedge clk);
        preset = 1'b0;
    endtask

    // Raise xs at a negedge, hold it for 'hold' cycles, flip op right after
    // acceptance, and observe 'window' cycles. lat = cycles from accepted edge to fin.
    task automatic run_op(input logic [1:0] o, input int hold, input int window,
                          output int lat, output int busy_n, output int fin_n);
        @(negedge clk);
        op = o; xs = 1'b1;
        lat = -1; busy_n = 0; fin_n = 0;
        for (int j = 1; j <= window; j++) begin
            @(negedge clk);
            if (j == 1) op = ~o;
            if (busy) busy_n++;
            if (fin) begin
                fin_n++;
                if (lat < 0) lat = j - 1;
            end
            if (j >= hold) xs = 1'b0;
        end
    endtask

    typedef struct {
        logic [1:0]   op;
        bit           do_preset;
        int           hold;
        logic [N-1:0] a, b, c;
        logic [N-1:0] ea, eb, ec;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int lat, busy_n, fin_n, cnt;

        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, busy_n, fin_n;
        string tag;

        vecs[0] = '{2'b00, 1'b1, 1,  8'd10,  8'd10,  8'd10, 8'd10, 8'd10,  8'd20,  3};
        vecs[1] = '{2'b01, 1'b0, 1,  8'd0,   8'd0,   8'd0,  8'd10, 8'd10,  8'd0,   3};
        vecs[2] = '{2'b00, 1'b0, 1,  8'd0,   8'd0,   8'd0,  8'd10, 8'd10,  8'd20,  3};
        vecs[3] = '{2'b11, 1'b1, 1,  8'd10,  8'd10,  8'd10, 8'd10, 8'd10,  8'd30,  5};
        vecs[4] = '{2'b10, 1'b1, 10, 8'd10,  8'd10,  8'd10, 8'd20, 8'd10,  8'd10,  3};
        vecs[5] = '{2'b01, 1'b1, 1,  8'd50,  8'd7,   8'd1,  8'd50, 8'd7,   8'd43,  3};
        vecs[6] = '{2'b11, 1'b1, 1,  8'd1,   8'd2,   8'd3,  8'd1,  8'd2,   8'd6,   5};
        vecs[7] = '{2'b10, 1'b1, 1,  8'd200, 8'd100, 8'd9,  8'd44, 8'd100, 8'd9,   3};
        vecs[8] = '{2'b01, 1'b1, 1,  8'd5,   8'd9,   8'd0,  8'd5,  8'd9,   8'd252, 3};
        vecs[9] = '{2'b11, 1'b1, 1,  8'd200, 8'd100, 8'd250, 8'd200, 8'd100, 8'd38, 5};

        // Reset state
        #1;
        check("reset_outs_async", int'(outs), 0);
        repeat (3) @(negedge clk);
        check("reset_outs_held", int'(outs), 0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_after_release", int'(outs), 0);

        // Table-driven runs
        foreach (vecs[i]) begin
            if (vecs[i].do_preset) preset_regs(vecs[i].a, vecs[i].b, vecs[i].c);
            run_op(vecs[i].op, vecs[i].hold, 14, lat, busy_n, fin_n);
            tag = $sformatf("vec%0d", i);
            check({tag, "_latency"}, lat, vecs[i].lat);
            check({tag, "_busy_cycles"}, busy_n, vecs[i].lat + 1);
            check({tag, "_fin_count"}, fin_n, 1);
            check({tag, "_A"}, int'(ra), int'(vecs[i].ea));
            check({tag, "_B"}, int'(rb), int'(vecs[i].eb));
            check({tag, "_C"}, int'(rc), int'(vecs[i].ec));
        end

        // Reset during OPERATE of op 00
        preset_regs(8'd10, 8'd10, 8'd10);
        @(negedge clk);
        op = 2'b00; xs = 1'b1;
        @(negedge clk);          // LOAD_T
        xs = 1'b0;
        @(negedge clk);          // OPERATE
        check("mid_busy_before_reset", int'(busy), 1);
        check("mid_rb_before_reset", int'(Rb), 1);
        reset = 1'b0;
        #1;
        check("mid_outs_on_reset", int'(outs), 0);
        fin_n = 0; busy_n = 0;
        repeat (2) begin
            @(negedge clk);
            fin_n += int'(fin); busy_n += int'(busy);
        end
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            fin_n += int'(fin); busy_n += int'(busy);
        end
        check("abort_fin_count", fin_n, 0);
        check("abort_busy_count", busy_n, 0);
        check("abort_C_kept", int'(rc), 10);
        run_op(2'b00, 1, 14, lat, busy_n, fin_n);
        check("after_abort_latency", lat, 3);
        check("after_abort_C", int'(rc), 20);

        // xs held high through reset release is not a start
        preset_regs(8'd10, 8'd10, 8'd10);
        @(negedge clk);
        reset = 1'b0; xs = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        busy_n = 0;
        repeat (6) begin
            @(negedge clk);
            busy_n += int'(busy);
        end
        check("xs_high_release_busy", busy_n, 0);
        xs = 1'b0;
        run_op(2'b00, 1, 14, lat, busy_n, fin_n);
        check("post_release_latency", lat, 3);
        check("post_release_C", int'(rc), 20);

        // A rising edge of xs while busy is neither acted on nor queued
        preset_regs(8'd10, 8'd10, 8'd10);
        @(negedge clk);
        op = 2'b11; xs = 1'b1;
        lat = -1; busy_n = 0; fin_n = 0;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (fin) begin
                fin_n++;
                if (lat < 0) lat = j - 1;
            end
            xs = (j == 2);
        end
        check("busy_edge_latency", lat, 5);
        check("busy_edge_busy_cycles", busy_n, 6);
        check("busy_edge_fin_count", fin_n, 1);
        check("busy_edge_C", int'(rc), 30);

        check("bus_exclusive_cycles_bad", excl_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
